// File: rtl/scan_encoder16t4_if.sv
// Handshake/bus bundle for the sequential 16-to-4 scan encoder.
// The master drives En/Start/Y. The slave returns the registered scan results.
interface scan_encoder16t4_if #(
  parameter int N  = 16,
  parameter int IW = 4
);
  logic          En;
  logic          Start;
  logic [0:N-1]  Y;
  logic [IW-1:0] W;
  logic          Valid;
  logic          Busy;
  logic          Done;
  logic          z;
  logic [IW:0]   Count;

  // Valid and Done are single-cycle strobes and are never back-pressured.
  // Start is taken only when the slave is idle and En=1. A Start seen while
  // Busy=1 is dropped, not queued. W is meaningful only while Valid=1.
  // z and Count hold from Done until the next accepted Start.
  modport master (output En, Start, Y, input W, Valid, Busy, Done, z, Count);
  modport slave  (input En, Start, Y, output W, Valid, Busy, Done, z, Count);
endinterface

// File: rtl/scan_encoder16t4.sv
// Sequential 16-to-4 encoder: captures a line vector on Start and emits the index of each set line.
// Define SCAN_FAST_EN to skip clear lines (scan length max(popcount,1)) instead of the fixed 16-cycle scan.
module scan_encoder16t4 #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  scan_encoder16t4_if.slave  bus,
  output logic [0:0]         dbg_state_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [0:N-1]  shadow_q, shadow_d;
  logic [IW-1:0] w_q, w_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          z_q, z_d;
  logic [IW:0]   count_q, count_d;
`ifdef SCAN_FAST_EN
  logic          found;
  logic [IW-1:0] low_idx;
  logic [0:N-1]  rest;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    w_d      = w_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    z_d      = z_q;
    count_d  = count_q;
`ifdef SCAN_FAST_EN
    found    = 1'b0;
    low_idx  = '0;
    rest     = shadow_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.En && bus.Start) begin
          shadow_d = bus.Y;
          cnt_d    = '0;
          count_d  = '0;
          z_d      = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (bus.En) begin
`ifdef SCAN_FAST_EN
          // Descending walk so the last hit is the lowest set index.
          for (int i = N - 1; i >= 0; i--) begin
            if (shadow_q[i]) begin
              found   = 1'b1;
              low_idx = IW'(i);
            end
          end
          if (found) begin
            rest[low_idx] = 1'b0;
            w_d           = low_idx;
            valid_d       = 1'b1;
            count_d       = count_q + (IW+1)'(1);
            z_d           = 1'b1;
          end
          shadow_d = rest;
          if (rest == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
`else
          if (shadow_q[cnt_q]) begin
            w_d     = cnt_q;
            valid_d = 1'b1;
            count_d = count_q + (IW+1)'(1);
            z_d     = 1'b1;
          end
          cnt_d = cnt_q + IW'(1);
          if (cnt_q == IW'(N - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      w_q      <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      z_q      <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      w_q      <= w_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      z_q      <= z_d;
      count_q  <= count_d;
    end
  end

  assign bus.W       = w_q;
  assign bus.Valid   = valid_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.z       = z_q;
  assign bus.Count   = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_encoder16t4.sv
// Directed bench for scan_encoder16t4: scoreboarded W/Valid timing, Done/Busy, z/Count and decoder loopback.
// Expected edge timing follows the linear scan, or the fast scan when SCAN_FAST_EN is defined.
module tb_scan_encoder16t4;
  localparam int N  = 16;
  localparam int IW = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [0:0] dbg_state;

  scan_encoder16t4_if #(.N(N), .IW(IW)) bus ();

  scan_encoder16t4 #(.N(N), .IW(IW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 Clock = ~Clock;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [IW-1:0] exp_q[$];
  int            exp_t_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int popcnt(input logic [0:N-1] y);
    int c = 0;
    for (int k = 0; k < N; k++) if (y[k]) c++;
    return c;
  endfunction

  // Edge (counted from the Start edge) that reports line k, the rank-th set line.
  function automatic int exp_edge(input int k, input int rank);
`ifdef SCAN_FAST_EN
    return rank + 0 * k;
`else
    return k + 1 + 0 * rank;
`endif
  endfunction

  function automatic int done_edge_of(input int pop);
`ifdef SCAN_FAST_EN
    return (pop == 0) ? 1 : pop;
`else
    return N + 0 * pop;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w"},     32'(bus.W), 0);
    chk({tag, "_valid"}, 32'(bus.Valid), 0);
    chk({tag, "_busy"},  32'(bus.Busy), 0);
    chk({tag, "_done"},  32'(bus.Done), 0);
    chk({tag, "_z"},     32'(bus.z), 0);
    chk({tag, "_count"}, 32'(bus.Count), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // Start a scan of y, optionally pausing En for pause_len edges from edge pause_at,
  // optionally toggling Start while busy. Returns after sampling the Done cycle.
  task automatic run_scan(input logic [0:N-1] y, input int pause_at, input int pause_len,
                          input bit noise);
    int            rank = 0;
    int            pop;
    int            de;
    int            ee;
    bit            ev;
    logic [0:N-1]  dec;
    logic [IW-1:0] w_exp;
    exp_q.delete();
    exp_t_q.delete();
    pop = popcnt(y);
    for (int k = 0; k < N; k++) begin
      if (y[k]) begin
        rank++;
        ee = exp_edge(k, rank);
        if (pause_len > 0 && ee >= pause_at) ee += pause_len;
        exp_q.push_back(IW'(k));
        exp_t_q.push_back(ee);
      end
    end
    de = done_edge_of(pop);
    if (pause_len > 0 && de >= pause_at) de += pause_len;

    bus.En    = 1'b1;
    bus.Start = 1'b1;
    bus.Y     = y;
    tick();
    bus.Start = 1'b0;
    bus.Y     = N'($urandom);
    chk("start_busy",  32'(bus.Busy), 1);
    chk("start_valid", 32'(bus.Valid), 0);
    chk("start_done",  32'(bus.Done), 0);
    chk("start_z",     32'(bus.z), 0);
    chk("start_count", 32'(bus.Count), 0);

    dec = '0;
    for (int e = 1; e <= de; e++) begin
      bus.En    = !(pause_len > 0 && e >= pause_at && e < pause_at + pause_len);
      bus.Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.Y     = N'($urandom);
      tick();
      ev = (exp_t_q.size() != 0) && (exp_t_q[0] == e);
      chk("valid", 32'(bus.Valid), 32'(ev));
      if (ev) begin
        w_exp = exp_q.pop_front();
        void'(exp_t_q.pop_front());
        chk("w", 32'(bus.W), 32'(w_exp));
      end
      if (bus.Valid === 1'b1) dec[bus.W] = 1'b1;
      chk("done", 32'(bus.Done), 32'(e == de));
      chk("busy", 32'(bus.Busy), 32'(e < de));
    end
    bus.Start = 1'b0;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("z",        32'(bus.z), 32'(pop != 0));
    chk("count",    32'(bus.Count), 32'(pop));
    chk("loopback", 32'(dec), 32'(y));
  endtask

  initial begin
    logic [0:N-1] y;
    int           pre;
    Reset     = 1'b1;
    bus.En    = 1'b0;
    bus.Start = 1'b0;
    bus.Y     = '0;
    tick();
    tick();
    chk_all_zero("reset");
    Reset = 1'b0;

    // Start with En low must be ignored.
    bus.Start = 1'b1;
    bus.Y     = '1;
    tick();
    chk("en_low_busy", 32'(bus.Busy), 0);
    bus.Start = 1'b0;
    tick();

    // Lines 1,3,6,7,9,14,15, then an all-zero scan started in the Done cycle.
    y = '0;
    y[1] = 1'b1; y[3] = 1'b1; y[6] = 1'b1; y[7] = 1'b1;
    y[9] = 1'b1; y[14] = 1'b1; y[15] = 1'b1;
    run_scan(y, 0, 0, 1'b0);
    run_scan('0, 0, 0, 1'b0);
    tick();

    run_scan('1, 0, 0, 1'b0);
    tick();

    // Line 5 only, En dropped for 3 edges at counter=2, Start noise while busy.
    y = '0;
    y[5] = 1'b1;
    run_scan(y, 3, 3, 1'b1);
    tick();

    // Reset mid-scan before line 10 is reached.
    y = '0;
    y[10] = 1'b1;
`ifdef SCAN_FAST_EN
    pre = 0;
`else
    pre = 5;
`endif
    bus.En    = 1'b1;
    bus.Start = 1'b1;
    bus.Y     = y;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < pre; i++) begin
      tick();
      chk("pre_reset_valid", 32'(bus.Valid), 0);
      chk("pre_reset_done",  32'(bus.Done), 0);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_all_zero("mid_reset");
    run_scan(y, 0, 0, 1'b0);
    tick();

    // Random vectors through the decoder loopback.
    for (int r = 0; r < 4; r++) begin
      y = N'($urandom);
      run_scan(y, 0, 0, 1'b0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
